// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
// Holds the FSM state encoding, default sizes and the code-to-one-hot mapping.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEF_CODE_W = 3;
  localparam int DEF_N_OUT  = 8;
  localparam int MAX_N_OUT  = 256;

  // Codes outside the populated output range map to all-zero.
  function automatic logic [MAX_N_OUT-1:0] onehot(input int unsigned code, input int unsigned nOut);
    logic [MAX_N_OUT-1:0] v;
    v = '0;
    if ((code < nOut) && (code < MAX_N_OUT)) begin
      v[code[7:0]] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_hold_timer.sv
// Loadable down-counter with a zero flag; used to time the hold and gap phases.
// Load takes priority over decrement, and the count saturates at zero.
module hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential N-to-2^N decoder: drives a timed one-hot strobe, then a quiet gap.
// Define ONEHOT_DEC_SKID_EN to add a one-entry buffer for back-to-back codes.
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int CODE_W      = DEF_CODE_W,
  parameter int N_OUT       = DEF_N_OUT,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [N_OUT-1:0]  D,
  output logic              d_valid,
  output logic              done,
  output logic              err
);

  localparam int HG_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int T_MAX  = (HG_MAX > 2) ? HG_MAX : 2;
  localparam int TW     = $clog2(T_MAX);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
  localparam int unsigned N_OUT_U = N_OUT;

  state_e           state_q, state_d;
  logic [N_OUT-1:0] d_q, d_d;
  logic             err_q, err_d;
  logic             holdLoad, gapLoad;
  logic             holdZero, gapZero;
  logic             transfer;

`ifdef ONEHOT_DEC_SKID_EN
  logic              bufValid_q, bufValid_d;
  logic [CODE_W-1:0] bufCode_q, bufCode_d;
  logic              finishing;

  // High on the final cycle of a strobe+gap sequence, when a buffered code may launch.
  assign finishing = ((state_q == DRIVE) && holdZero && (GAP_CYCLES == 0)) ||
                     ((state_q == GAP) && gapZero);
`endif

  assign transfer = in_valid && in_ready;

  hold_timer #(.W(TW)) holdTimer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (holdLoad),
    .load_val_i (HOLD_LOAD),
    .dec_i      (state_q == DRIVE),
    .zero_o     (holdZero)
  );

  hold_timer #(.W(TW)) gapTimer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gapLoad),
    .load_val_i (GAP_LOAD),
    .dec_i      (state_q == GAP),
    .zero_o     (gapZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      err_q      <= 1'b0;
`ifdef ONEHOT_DEC_SKID_EN
      bufValid_q <= 1'b0;
      bufCode_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      err_q      <= err_d;
`ifdef ONEHOT_DEC_SKID_EN
      bufValid_q <= bufValid_d;
      bufCode_q  <= bufCode_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    err_d    = 1'b0;
    holdLoad = 1'b0;
    gapLoad  = 1'b0;
`ifdef ONEHOT_DEC_SKID_EN
    bufValid_d = bufValid_q;
    bufCode_d  = bufCode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          if (32'(in_code) < N_OUT_U) begin
            state_d  = DRIVE;
            d_d      = N_OUT'(onehot(32'(in_code), N_OUT_U));
            holdLoad = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (holdZero) begin
          d_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gapLoad = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gapZero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        d_d     = '0;
      end
    endcase
`ifdef ONEHOT_DEC_SKID_EN
    // A buffered code bypasses IDLE; a same-edge transfer refills the emptied slot.
    if (finishing && bufValid_q) begin
      bufValid_d = 1'b0;
      if (32'(bufCode_q) < N_OUT_U) begin
        state_d  = DRIVE;
        d_d      = N_OUT'(onehot(32'(bufCode_q), N_OUT_U));
        holdLoad = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (transfer && (state_q != IDLE)) begin
      bufValid_d = 1'b1;
      bufCode_d  = in_code;
    end
`endif
  end

  always_comb begin
`ifdef ONEHOT_DEC_SKID_EN
    in_ready = !rst && ((state_q == IDLE) || !bufValid_q);
`else
    in_ready = !rst && (state_q == IDLE);
`endif
    D       = d_q;
    d_valid = |d_q;
    done    = (state_q == DRIVE) && holdZero;
    err     = err_q;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Sequential N-to-2^N decoder, the receive-side counterpart of the 8-to-3 priority encoder. It accepts an encoded index over a valid/ready handshake. It drives the matching one-hot line for a programmable hold time, then enforces a quiet gap. Used to turn encoder output back into timed one-hot strobes (select/enable lines).

Parameters:
CODE_W, 3, width of the encoded input index
N_OUT, 8, number of one-hot output lines; legal range 2..2**CODE_W
HOLD_CYCLES, 4, cycles the one-hot output is held; must be >= 1
GAP_CYCLES, 1, all-zero cycles forced after each hold; >= 0

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  encoded index is valid
in_code  input  CODE_W  encoded index to decode
in_ready  output  1  block can accept in_code this cycle
D  output  N_OUT  registered one-hot output; all-zero when idle
d_valid  output  1  high while D carries a decoded line
done  output  1  one-cycle pulse on the last hold cycle
err  output  1  one-cycle pulse when in_code >= N_OUT is accepted

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, D=0, d_valid=0, done=0, err=0, counters=0. in_ready=0 while rst is high.
- States: IDLE, DRIVE, GAP.
- Transfer occurs on a rising edge where in_valid && in_ready. in_ready = (state==IDLE) && !rst (skid variant below).
- IDLE + transfer, in_code < N_OUT:
  - Next cycle: state=DRIVE, D = 1 << in_code, d_valid=1.
  - Hold counter is loaded with HOLD_CYCLES-1.
- IDLE + transfer, in_code >= N_OUT:
  - err=1 for the next cycle only. D stays 0. State stays IDLE.
  - Not reachable when N_OUT == 2**CODE_W.
- DRIVE:
  - D is held constant. Counter decrements each cycle.
  - When the counter is 0: done=1 that cycle. Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
  - D is held for exactly HOLD_CYCLES cycles.
- GAP: D=0, d_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency: D is valid one cycle after the accepting edge.
- Base throughput: one transfer per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Invariants:
  - D is one-hot or zero every cycle. d_valid == |D.
  - done and err are never high together.
- in_code is sampled only at transfer; changes at any other time are ignored.
- Reset mid-DRIVE/GAP: D clears asynchronously, with no done pulse. Any pending buffered entry is discarded.

Optional Feature:
Macro: ONEHOT_DEC_SKID_EN
- Defined:
  - Adds a one-entry buffer. in_ready = !rst && (state==IDLE || buffer empty).
  - A transfer during DRIVE or GAP loads the buffer.
  - On leaving the last DRIVE cycle (GAP_CYCLES=0) or the last GAP cycle, a full buffer launches directly into DRIVE, skipping IDLE. Back-to-back throughput becomes HOLD_CYCLES+GAP_CYCLES.
  - An out-of-range buffered code raises err in its launch cycle. The block then returns to IDLE.
  - If a transfer and a launch happen on the same edge, the buffer is refilled; no loss.
- Undefined: no buffer. Behaviour is exactly as above, and the buffer-related logic is absent.

Decomposition:
- Package onehot_dec_pkg:
  - State enum {IDLE, DRIVE, GAP}.
  - Default CODE_W/N_OUT constants.
  - Pure function onehot(code), returning zero for out-of-range codes.
- Sub-module hold_timer:
  - Down-counter with load/decrement/zero flag.
  - Instantiated twice, for hold and gap.
  - Width clog2(max(HOLD_CYCLES, GAP_CYCLES, 2)).

Test Plan:
- Reset release, then in_code=3'd0: D=8'b00000001 one cycle after the accepting edge, held 4 cycles. done on the 4th cycle. D=0 for 1 gap cycle. in_ready high again 6 cycles after the accept.
- Sweep in_code 0..7 with default parameters: each returns D=1<<code, d_valid=1. Encoder round-trip against priority_encoder_8to3 gives Y==code, valid=1.
- in_valid held high with in_code=3'd7 continuously: transfers exactly every 6 cycles; with ONEHOT_DEC_SKID_EN, every 5 cycles with no all-zero idle cycle beyond the gap.
- rst asserted on the 2nd DRIVE cycle of code 3'd5: D=0 and in_ready=0 immediately (same cycle, asynchronous). No done pulse. After release, a new code 3'd2 decodes normally.
- N_OUT=6, in_code=3'd6: err pulse 1 cycle. D stays 0, d_valid=0. Next in_code=3'd5 gives D=6'b100000.
- Change in_code while in DRIVE with in_valid=0: D unchanged for the remaining hold cycles.
